pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
// - Central stall/flush sequencer for the 5-stage pipeline; sits beside the ID/EX hazard logic.
// - Consumes the EX-stage PCSel from the branch decision unit, load-use hazard info and dmem busy.
// - Drives PC and pipeline-register enables and flushes; flags stuck memory; optional perf counters.
// PARAMETERS
// - BUSY_TIMEOUT  default 255  consecutive mem_busy cycles before busy_timeout sets; 0 disables
// - CNT_W         default 32   perf counter width (used only with PERF_CNT_EN)
// PORTS
// - clk          in   1      single clock, all state on rising edge
// - rst          in   1      synchronous, active-high reset
// - ex_pc_sel    in   1      taken branch/jump resolved in EX (PCSel from the branch decision unit)
// - ex_mem_read  in   1      instruction in EX is a load
// - ex_rd        in   5      destination register of the EX instruction
// - id_rs1       in   5      ID source register 1
// - id_rs2       in   5      ID source register 2
// - id_use_rs1   in   1      ID instruction reads rs1
// - id_use_rs2   in   1      ID instruction reads rs2
// - mem_busy     in   1      data memory not ready; whole pipeline must freeze
// - pc_en        out  1      PC register write enable
// - if_id_en     out  1      IF/ID register enable
// - if_id_flush  out  1      IF/ID loads NOP
// - id_ex_en     out  1      ID/EX register enable
// - id_ex_flush  out  1      ID/EX loads bubble
// - ex_mem_en    out  1      EX/MEM register enable
// - mem_wb_en    out  1      MEM/WB register enable
// - busy_timeout out  1      sticky: mem_busy exceeded BUSY_TIMEOUT
// - state_o      out  2      FSM state: 0 RUN, 1 LU_STALL, 2 MEM_WAIT, 3 FLUSH
// BEHAVIOUR
// - Clock clk; reset rst is synchronous, active-high.
// - rst=1: next edge state=RUN, timeout counter=0, busy_timeout=0, perf counters=0.
//   While rst=1, outputs are pc_en=0, all *_en=0 and if_id_flush=id_ex_flush=1.
// - lu_hit = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
// - Outputs are combinational (same cycle) from state and inputs; decisions are registered in the FSM.
// - Decisions are taken in priority order:
//   1) mem_busy=1: all enables 0, both flushes 0. Next state=MEM_WAIT; a branch is deferred, not lost.
//   2) ex_pc_sel=1 and state!=FLUSH: all enables 1, if_id_flush=id_ex_flush=1. Next state=FLUSH.
//   3) lu_hit=1 and state!=LU_STALL: pc_en=if_id_en=0, id_ex_flush=1, others en=1. Next state=LU_STALL.
//   4) Otherwise all enables 1, flushes 0. Next state=RUN.
// - FLUSH: ex_pc_sel is ignored, since EX holds a bubble. LU_STALL: lu_hit is ignored.
//   Both states last exactly one cycle unless mem_busy arrives.
// - MEM_WAIT: remains while mem_busy=1. On the first !mem_busy cycle, rules 2-4 apply normally.
//   That cycle therefore acts on a deferred branch or load-use.
// - Timeout counter: +1 each cycle mem_busy=1 (saturates at BUSY_TIMEOUT); cleared when mem_busy=0.
//   When the count reaches BUSY_TIMEOUT, busy_timeout=1 from the next cycle until rst.
// - ex_rd==0 never stalls. A simultaneous branch and load-use resolves as branch: the ID instruction is squashed.
// CONFIGURATION
// - PERF_CNT_EN defined: adds outputs perf_stall_cnt[CNT_W-1:0] and perf_flush_cnt[CNT_W-1:0].
//   perf_stall_cnt: +1 per rule-1 or rule-3 cycle. perf_flush_cnt: +1 per rule-2 cycle.
//   Both wrap modulo 2^CNT_W and reset to 0.
// - PERF_CNT_EN undefined: these ports and registers do not exist; all other behaviour is identical.
// TESTING
// - Release rst; idle inputs -> state_o=0, all en=1, flushes=0, busy_timeout=0.
// - ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for 2 cycles
//   -> cycle1 pc_en=0,if_id_en=0,id_ex_flush=1,state->1; cycle2 no stall,state->0.
// - ex_pc_sel=1 for 2 cycles -> cycle1 if_id_flush=id_ex_flush=1,state->3; cycle2 no flush.
// - mem_busy=1 with ex_pc_sel=1 for 3 cycles, then mem_busy=0
//   -> 3 cycles all en=0,flush=0,state=2; 4th cycle flushes=1,state->3.
// - BUSY_TIMEOUT=4, mem_busy=1 for 6 cycles -> busy_timeout=1 after 4th busy cycle;
//   stays 1 after mem_busy=0 until rst.
// - Load-use hit with ex_rd=0 -> no stall. Assert rst during MEM_WAIT -> next cycle state_o=0,
//   counters 0 (with PERF_CNT_EN: perf_stall_cnt=0).

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage pipeline. It decides every cycle whether
// the pipeline freezes on data-memory backpressure, squashes IF/ID and ID/EX on a taken
// EX-stage branch, or inserts one bubble for a load-use hazard. Outputs are combinational
// from the registered state and the current inputs. Stuck memory is flagged by a sticky bit.
//
// Parameters:
//   BUSY_TIMEOUT  consecutive mem_busy cycles before busy_timeout sets (0 disables)
//   CNT_W         perf counter width (only with PERF_CNT_EN)
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ex_pc_sel                 taken branch/jump resolved in EX
//   ex_mem_read, ex_rd        EX instruction is a load, and its destination register
//   id_rs1/2, id_use_rs1/2    ID source registers and whether they are read
//   mem_busy                  data memory not ready, freeze everything
//   pc_en, *_en               PC and pipeline-register write enables
//   if_id_flush, id_ex_flush  load NOP / bubble into IF/ID, ID/EX
//   busy_timeout              sticky stuck-memory flag
//   state_o                   0 RUN, 1 LU_STALL, 2 MEM_WAIT, 3 FLUSH
//   perf_stall_cnt/flush_cnt  stall and flush event counters (only with PERF_CNT_EN)
//
// Build option: define PERF_CNT_EN to add the perf counter outputs.

module pipeline_hazard_ctrl #(
  parameter int unsigned BUSY_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_pc_sel,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             busy_timeout,
  output logic [1:0]       state_o
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StMemWait = 2'd2,
    StFlush   = 2'd3
  } state_e;

  localparam int unsigned TimW = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;
  localparam logic [TimW-1:0] TimMax = TimW'(BUSY_TIMEOUT);

  state_e          state_q, state_d;
  logic [TimW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            busy_timeout_q, busy_timeout_d;
  logic            lu_hit;
  logic            stall_evt;
  logic            flush_evt;

  // x0 is hardwired zero, so a load targeting it never creates a hazard.
  assign lu_hit = ex_mem_read && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    state_d     = StRun;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;

    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (mem_busy) begin
      // Freeze; a pending branch or load-use stays in EX/ID and is acted on after release.
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      state_d   = StMemWait;
      stall_evt = 1'b1;
    end else if (ex_pc_sel && (state_q != StFlush)) begin
      // Branch wins over load-use: the ID instruction is squashed anyway.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = StFlush;
      flush_evt   = 1'b1;
    end else if (lu_hit && (state_q != StLuStall)) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      state_d     = StLuStall;
      stall_evt   = 1'b1;
    end
  end

  always_comb begin
    tmo_cnt_d = '0;
    if (mem_busy) begin
      tmo_cnt_d = (tmo_cnt_q != TimMax) ? tmo_cnt_q + TimW'(1) : tmo_cnt_q;
    end
    busy_timeout_d = busy_timeout_q ||
                     ((BUSY_TIMEOUT != 0) && mem_busy && (tmo_cnt_d == TimMax));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StRun;
      tmo_cnt_q      <= '0;
      busy_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmo_cnt_q      <= tmo_cnt_d;
      busy_timeout_q <= busy_timeout_d;
    end
  end

  assign busy_timeout = busy_timeout_q;
  assign state_o      = state_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_evt) perf_stall_q <= perf_stall_q + CNT_W'(1);
      if (flush_evt) perf_flush_q <= perf_flush_q + CNT_W'(1);
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  logic unused_evt;
  assign unused_evt = stall_evt ^ flush_evt;
`endif

endmodule
